activation_pipe: RTL
====================

// Module: activation_pipe
// PURPOSE
//  Streaming, multi-lane activation stage placed between a dense-layer accumulator and the next layer / latent sampler.
//  Applies ReLU, leaky ReLU, piecewise-linear sigmoid or pass-through to LANES signed fixed-point elements per beat.
//  Two-stage registered pipeline with valid/ready handshake, full backpressure and per-frame mode latching.
// PARAMETERS
//  LANES   4    elements per beat
//  WIDTH   10   signed element width, two's complement
//  FRAC    6    fractional bits; legal iff FRAC>=5 and WIDTH>=FRAC+4 (elaboration error otherwise)
//  ALPHA_SH 3   leaky-ReLU slope = 2^-ALPHA_SH (arithmetic shift)
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            reset, synchronous active-low
//  mode       in   2            00 ReLU, 01 leaky ReLU, 10 sigmoid PWL, 11 pass-through
//  in_valid   in   1            input beat valid
//  in_ready   out  1            input beat accepted when in_valid&&in_ready
//  in_data    in   LANES*WIDTH  lane i = bits [i*WIDTH +: WIDTH]
//  in_last    in   1            final beat of frame
//  out_valid  out  1            output beat valid
//  out_ready  in   1            downstream accepts when out_valid&&out_ready
//  out_data   out  LANES*WIDTH  activated lanes, same packing
//  out_last   out  1            in_last delayed with its beat
//  busy       out  1            frame open or any stage valid
//  sat_cnt    out  16           count of sigmoid lanes whose |x| was clamped to 1.0 (|x|>=5.0); saturates at 0xFFFF
// BEHAVIOUR
//  - Reset (rst_n low at posedge): s1_valid, s2_valid, frame_open, mode_q, sat_cnt cleared; out_data/out_last 0;
//    in_ready forced 0 while rst_n low. Reset mid-frame discards all in-flight beats; no partial output.
//  - Latency 2 cycles in->out with no stall; throughput 1 beat/cycle.
//  - Advance: s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en && rst_n.
//    Bubbles collapse; out_data/out_last stable while out_valid && !out_ready.
//  - Mode latch: on an accepted beat with frame_open==0, mode_q<=mode and frame_open<=1 (unless in_last).
//    Accepted beat with in_last clears frame_open. Beat uses mode if frame_open==0 else mode_q.
//    Mode travels with the beat through the pipe; mid-frame mode changes are ignored.
//  - Stage 1: per lane register x, |x| (most-negative value -> max positive), sign, segment index, mode, last.
//  - Stage 2: per lane result, registered into out_data:
//    ReLU: x>0 ? x : 0.  Leaky: x>0 ? x : x>>>ALPHA_SH.  Pass: x.
//    Sigmoid, a=|x|, ONE=2^FRAC, constants truncated from real values scaled by ONE:
//      a<1.0:        y = (a>>>2) + 0.5
//      1.0<=a<2.375: y = (a>>>3) + 0.625
//      2.375<=a<5.0: y = (a>>>5) + 0.84375
//      a>=5.0:       y = ONE; sat_cnt++ per such lane on stage-2 load
//      x<0 -> ONE - y.  Result always within [0,ONE].
//  - Widths: intermediates WIDTH+1 bits; shifts truncate toward -inf; no output wraps.
//  - sat_cnt increments by popcount of clamped lanes in the beat, saturating.
//  - Simultaneous out_ready=0 with in_valid: pipe fills 2 beats then in_ready=0.
// STRUCTURE
//  - Shared package: mode encodings (ACT_RELU, ACT_LEAKY, ACT_SIGM, ACT_PASS); sigmoid breakpoints/offsets as
//    real constants converted per FRAC by a function.
//  - One sub-module: act_lane (single-lane stage-1/stage-2 datapath, enables from parent), generated LANES times.
//  - Parent owns handshake, frame/mode latch, sat_cnt.
// TESTING  (WIDTH=10, FRAC=6, LANES=4, ALPHA_SH=3)
//  - ReLU beat {-5,37,0,-512}, out_ready=1 -> {0,37,0,0} exactly 2 cycles later, out_last follows in_last.
//  - Leaky beat {-64,64,-1,-512} -> {-8,64,-1,-64}.
//  - Sigmoid beat {0,64,-64,128} -> {32,48,16,56};
//    beat {384,-384,320,-512} -> {64,0,64,0}, sat_cnt += 4.
//  - Backpressure: 6 back-to-back beats, out_ready low cycles 3-6 -> in_ready drops after 2 held beats,
//    out_data stable while stalled, all 6 beats out in order, none lost or duplicated.
//  - Mode latch: frame of 3 beats begun in ReLU, mode=sigmoid on beat 2 -> all 3 beats ReLU;
//    next frame's first beat takes sigmoid.
//  - Reset mid-frame with 2 beats in flight -> out_valid=0, busy=0, sat_cnt=0 next cycle;
//    next frame latches fresh mode.

Source files
------------

// File: rtl/activation_pipe_pkg.sv
// Shared definitions for the activation pipe: mode encodings, sigmoid segment
// indices and the real-valued PWL constants that are scaled to fixed point per FRAC.
package activation_pipe_pkg;

    typedef enum logic [1:0] {
        ACT_RELU  = 2'b00,
        ACT_LEAKY = 2'b01,
        ACT_SIGM  = 2'b10,
        ACT_PASS  = 2'b11
    } act_mode_e;

    typedef enum logic [1:0] {
        SEG_LO  = 2'd0,
        SEG_MID = 2'd1,
        SEG_HI  = 2'd2,
        SEG_SAT = 2'd3
    } sig_seg_e;

    localparam real SIG_BRK1 = 1.0;
    localparam real SIG_BRK2 = 2.375;
    localparam real SIG_BRK3 = 5.0;
    localparam real SIG_OFS0 = 0.5;
    localparam real SIG_OFS1 = 0.625;
    localparam real SIG_OFS2 = 0.84375;

    // Real constant scaled by 2^frac, truncated toward zero.
    function automatic int fx_const(input real val, input int frac);
        real scale;
        scale = 1.0;
        for (int i = 0; i < frac; i++) scale = scale * 2.0;
        return $rtoi(val * scale);
    endfunction

endpackage

// File: rtl/activation_pipe_lane.sv
// Single-lane datapath: stage 1 registers x, |x|, sign and sigmoid segment;
// stage 2 registers the activated result. Load enables come from the parent.
module act_lane
    import activation_pipe_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int FRAC     = 6,
    parameter int ALPHA_SH = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ld1,
    input  logic                    i_ld2,
    input  logic signed [WIDTH-1:0] i_x,
    input  act_mode_e               i_mode,
    output logic        [WIDTH-1:0] o_y,
    output logic                    o_clamp
);

    localparam int EW = WIDTH + 1;
    localparam logic [EW-1:0]    ONE     = EW'(fx_const(1.0, FRAC));
    localparam logic [EW-1:0]    BRK1    = EW'(fx_const(SIG_BRK1, FRAC));
    localparam logic [EW-1:0]    BRK2    = EW'(fx_const(SIG_BRK2, FRAC));
    localparam logic [EW-1:0]    BRK3    = EW'(fx_const(SIG_BRK3, FRAC));
    localparam logic [EW-1:0]    OFS0    = EW'(fx_const(SIG_OFS0, FRAC));
    localparam logic [EW-1:0]    OFS1    = EW'(fx_const(SIG_OFS1, FRAC));
    localparam logic [EW-1:0]    OFS2    = EW'(fx_const(SIG_OFS2, FRAC));
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

    logic signed [WIDTH-1:0] r_x;
    logic        [WIDTH-1:0] r_abs;
    logic                    r_neg;
    sig_seg_e                r_seg;
    logic        [WIDTH-1:0] r_y;

    logic        [WIDTH-1:0] w_abs;
    logic        [EW-1:0]    w_abs_e;
    sig_seg_e                w_seg;
    logic signed [EW-1:0]    w_xe;
    logic        [EW-1:0]    w_ae;
    logic        [EW-1:0]    w_sig;
    logic        [EW-1:0]    w_sig_s;
    logic        [EW-1:0]    w_res;
    logic                    w_pos;

    // The most-negative code has no positive twin, so it folds to max positive.
    always_comb begin
        w_abs = i_x;
        if (i_x == MIN_NEG)     w_abs = MAX_POS;
        else if (i_x[WIDTH-1])  w_abs = ~i_x + WIDTH'(1);
        w_abs_e = {1'b0, w_abs};
        w_seg   = SEG_SAT;
        if (w_abs_e < BRK1)      w_seg = SEG_LO;
        else if (w_abs_e < BRK2) w_seg = SEG_MID;
        else if (w_abs_e < BRK3) w_seg = SEG_HI;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_x   <= '0;
            r_abs <= '0;
            r_neg <= 1'b0;
            r_seg <= SEG_LO;
        end else if (i_ld1) begin
            r_x   <= i_x;
            r_abs <= w_abs;
            r_neg <= i_x[WIDTH-1];
            r_seg <= w_seg;
        end
    end

    assign w_xe = {r_x[WIDTH-1], r_x};
    assign w_ae = {1'b0, r_abs};
    assign w_pos = !r_x[WIDTH-1] && (r_x != '0);

    always_comb begin
        w_sig = ONE;
        case (r_seg)
            SEG_LO:  w_sig = (w_ae >> 2) + OFS0;
            SEG_MID: w_sig = (w_ae >> 3) + OFS1;
            SEG_HI:  w_sig = (w_ae >> 5) + OFS2;
            default: w_sig = ONE;
        endcase
        w_sig_s = r_neg ? (ONE - w_sig) : w_sig;
        w_res = '0;
        case (i_mode)
            ACT_RELU:  w_res = w_pos ? w_xe : '0;
            ACT_LEAKY: w_res = w_pos ? w_xe : (w_xe >>> ALPHA_SH);
            ACT_SIGM:  w_res = w_sig_s;
            default:   w_res = w_xe;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_y <= '0;
        else if (i_ld2) r_y <= w_res[WIDTH-1:0];
    end

    assign o_y     = r_y;
    assign o_clamp = (r_seg == SEG_SAT);

endmodule

// File: rtl/activation_pipe.sv
// Multi-lane two-stage activation pipe: valid/ready handshake with full
// backpressure, per-frame mode latch and a saturating sigmoid-clamp counter.
module activation_pipe
    import activation_pipe_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int WIDTH    = 10,
    parameter int FRAC     = 6,
    parameter int ALPHA_SH = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [1:0]             i_mode,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [LANES*WIDTH-1:0] i_in_data,
    input  logic                   i_in_last,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [LANES*WIDTH-1:0] o_out_data,
    output logic                   o_out_last,
    output logic                   o_busy,
    output logic [15:0]            o_sat_cnt
);

    localparam int PW = $clog2(LANES + 1);

    if (FRAC < 5 || WIDTH < FRAC + 4) begin : g_param_chk
        $error("activation_pipe: FRAC must be >= 5 and WIDTH >= FRAC+4");
    end

    logic [2:1]   r_vld_pipe;
    logic         r_frame_open;
    act_mode_e    r_mode_q;
    act_mode_e    r_s1_mode;
    logic         r_s1_last;
    logic         r_s2_last;
    logic [15:0]  r_sat_cnt;

    logic [LANES-1:0][WIDTH-1:0] w_lane_in;
    logic [LANES-1:0][WIDTH-1:0] w_lane_out;
    logic [LANES-1:0]            w_clamp;
    logic                        w_s1_en;
    logic                        w_s2_en;
    logic                        w_acc;
    logic                        w_ld2;
    act_mode_e                   w_beat_mode;
    logic [PW-1:0]               w_pop;
    logic [16:0]                 w_sat_sum;

    assign w_s2_en     = !r_vld_pipe[2] || i_out_ready;
    assign w_s1_en     = !r_vld_pipe[1] || w_s2_en;
    assign o_in_ready  = w_s1_en && i_rst_n;
    assign w_acc       = i_in_valid && o_in_ready;
    assign w_ld2       = w_s2_en && r_vld_pipe[1];
    assign w_beat_mode = r_frame_open ? r_mode_q : act_mode_e'(i_mode);
    assign w_lane_in   = i_in_data;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .WIDTH    (WIDTH),
            .FRAC     (FRAC),
            .ALPHA_SH (ALPHA_SH)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_ld1   (w_acc),
            .i_ld2   (w_ld2),
            .i_x     (w_lane_in[g]),
            .i_mode  (r_s1_mode),
            .o_y     (w_lane_out[g]),
            .o_clamp (w_clamp[g])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) w_pop = w_pop + PW'(w_clamp[i]);
        w_sat_sum = {1'b0, r_sat_cnt} + 17'(w_pop);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld_pipe   <= '0;
            r_frame_open <= 1'b0;
            r_mode_q     <= ACT_RELU;
            r_s1_mode    <= ACT_RELU;
            r_s1_last    <= 1'b0;
            r_s2_last    <= 1'b0;
            r_sat_cnt    <= '0;
        end else begin
            if (w_s1_en) r_vld_pipe[1] <= w_acc;
            if (w_s2_en) r_vld_pipe[2] <= r_vld_pipe[1];
            if (w_acc) begin
                r_s1_mode <= w_beat_mode;
                r_s1_last <= i_in_last;
                // The first beat of a frame fixes the mode for the rest of it.
                if (!r_frame_open) begin
                    r_mode_q     <= act_mode_e'(i_mode);
                    r_frame_open <= !i_in_last;
                end else if (i_in_last) begin
                    r_frame_open <= 1'b0;
                end
            end
            if (w_ld2) r_s2_last <= r_s1_last;
            if (w_ld2 && r_s1_mode == ACT_SIGM)
                r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
        end
    end

    assign o_out_valid = r_vld_pipe[2];
    assign o_out_data  = w_lane_out;
    assign o_out_last  = r_s2_last;
    assign o_busy      = r_frame_open || r_vld_pipe[1] || r_vld_pipe[2];
    assign o_sat_cnt   = r_sat_cnt;

endmodule
